// File: rtl/barrel_shifter_pipe.sv
// ---------------------------------------------------------------------------
// barrel_shifter_pipe
//   Pipelined barrel shifter with rotate-left, rotate-right, logical-left and
//   arithmetic-right modes. One register stage per shift-amount bit; stage k
//   applies a conditional shift/rotate by 2^k. Valid/ready on both sides,
//   one op per cycle when the consumer keeps up.
//
//   Optional feature: define BS_ZERO_FLAG_EN to add the registered o_zero
//   output (result == 0). Without it the port and its logic are absent.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand valid          in_ready  block can accept operand
//   in_reg     operand                shift_amt shift/rotate amount (unsigned)
//   in_m       mode: 00 ROL, 01 ROR, 10 SLL, 11 SRA
//   o_valid    result valid           o_ready   consumer accepts result
//   o_reg      result                 o_zero    result == 0 (BS_ZERO_FLAG_EN)
//
// Handshake: a transfer happens on a rising edge where valid && ready. A
// producer holds valid and payload until that edge; ready may depend
// combinationally on downstream ready (in_ready depends on o_ready).
// ---------------------------------------------------------------------------
module barrel_shifter_pipe #(
  parameter int WIDTH   = 32,
  parameter int LOG2W   = $clog2(WIDTH),
  parameter int SHAMT_W = LOG2W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_reg,
  input  logic [SHAMT_W-1:0] shift_amt,
  input  logic [1:0]         in_m,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [WIDTH-1:0]   o_reg
`ifdef BS_ZERO_FLAG_EN
  ,
  output logic               o_zero
`endif
);

  localparam logic [1:0] MODE_ROL = 2'b00;
  localparam logic [1:0] MODE_ROR = 2'b01;
  localparam logic [1:0] MODE_SLL = 2'b10;
  localparam logic [1:0] MODE_SRA = 2'b11;
  localparam int         LAST     = LOG2W - 1;

  // Per-stage state. Each stage carries the full amount and mode so later
  // stages never look at the live inputs; sat/sign are captured at S0.
  logic [LOG2W-1:0]              valid_q, valid_d;
  logic [LOG2W-1:0][WIDTH-1:0]   data_q,  data_d;
  logic [LOG2W-1:0][SHAMT_W-1:0] amt_q,   amt_d;
  logic [LOG2W-1:0][1:0]         mode_q,  mode_d;
  logic [LOG2W-1:0]              sat_q,   sat_d;
  logic [LOG2W-1:0]              sign_q,  sign_d;

  // Source of each stage: the input port for S0, the previous stage otherwise.
  logic [LOG2W-1:0]              src_valid;
  logic [LOG2W-1:0][WIDTH-1:0]   src_data;
  logic [LOG2W-1:0][SHAMT_W-1:0] src_amt;
  logic [LOG2W-1:0][1:0]         src_mode;
  logic [LOG2W-1:0]              src_sat;
  logic [LOG2W-1:0]              src_sign;

  logic [LOG2W-1:0] ready_c;
  logic             ready_acc;
  logic [WIDTH-1:0] step_res;

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       m,
                                                  input int               sh);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_ROL: r = (d << sh) | (d >> (WIDTH - sh));
      MODE_ROR: r = (d >> sh) | (d << (WIDTH - sh));
      MODE_SLL: r = d << sh;
      default:  r = $signed(d) >>> sh;
    endcase
    return r;
  endfunction

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    amt_d    = amt_q;
    mode_d   = mode_q;
    sat_d    = sat_q;
    sign_d   = sign_q;
    ready_c  = '0;
    step_res = '0;

    // ready_k = !valid_k || ready_(k+1), unrolled as "o_ready or any stage
    // at/after k is empty" so no vector feeds back on itself.
    ready_acc = o_ready;
    for (int k = LOG2W - 1; k >= 0; k--) begin
      ready_acc  = ready_acc | ~valid_q[k];
      ready_c[k] = ready_acc;
    end

    src_valid[0] = in_valid;
    src_data[0]  = in_reg;
    src_amt[0]   = shift_amt;
    src_mode[0]  = in_m;
    src_sat[0]   = shift_amt[SHAMT_W-1];   // amount >= WIDTH
    src_sign[0]  = in_reg[WIDTH-1];
    for (int k = 1; k < LOG2W; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_amt[k]   = amt_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_sat[k]   = sat_q[k-1];
      src_sign[k]  = sign_q[k-1];
    end

    for (int k = 0; k < LOG2W; k++) begin
      if (ready_c[k]) begin
        valid_d[k] = src_valid[k];
        if (src_valid[k]) begin
          step_res = src_amt[k][k] ? shift_step(src_data[k], src_mode[k], 1 << k)
                                   : src_data[k];
          // Rotates ignore the amount MSB; the shifts saturate on it.
          if (k == LAST && src_sat[k]) begin
            if (src_mode[k] == MODE_SLL) step_res = '0;
            else if (src_mode[k] == MODE_SRA) step_res = {WIDTH{src_sign[k]}};
          end
          data_d[k] = step_res;
          amt_d[k]  = src_amt[k];
          mode_d[k] = src_mode[k];
          sat_d[k]  = src_sat[k];
          sign_d[k] = src_sign[k];
        end
      end
    end
  end

`ifdef BS_ZERO_FLAG_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (ready_c[LAST] && src_valid[LAST]) zero_d = (data_d[LAST] == '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
      sat_q   <= '0;
      sign_q  <= '0;
`ifdef BS_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
      sat_q   <= sat_d;
      sign_q  <= sign_d;
`ifdef BS_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign in_ready = ready_c[0];
  assign o_valid  = valid_q[LAST];
  assign o_reg    = data_q[LAST];
`ifdef BS_ZERO_FLAG_EN
  assign o_zero   = zero_q;
`endif

  // The last stage's side-band and most amount bits are never consumed.
  logic unused_side;
  assign unused_side = ^{amt_q, mode_q, sat_q, sign_q};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// ---------------------------------------------------------------------------
// tb_barrel_shifter_pipe
//   Directed bench for barrel_shifter_pipe at WIDTH=32. Expected results are
//   hand-computed constants pushed into exp_q in issue order; a negedge
//   monitor pops one entry per output transfer and compares.
// ---------------------------------------------------------------------------
module tb_barrel_shifter_pipe;

  localparam logic [1:0] ROL = 2'b00;
  localparam logic [1:0] ROR = 2'b01;
  localparam logic [1:0] SLL = 2'b10;
  localparam logic [1:0] SRA = 2'b11;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_reg;
  logic [5:0]  shift_amt;
  logic [1:0]  in_m;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_reg;
`ifdef BS_ZERO_FLAG_EN
  logic        o_zero;
`endif

  barrel_shifter_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_reg    (in_reg),
    .shift_amt (shift_amt),
    .in_m      (in_m),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_reg     (o_reg)
`ifdef BS_ZERO_FLAG_EN
    ,
    .o_zero    (o_zero)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          out_cyc_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          n_unexpected = 0;
  int          cyc          = 0;
  logic [31:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: transfers are decided at the negedge because the bench
  // only changes o_ready just after a posedge.
  always @(negedge clk) begin
    cyc++;
    if (!rst && o_valid && o_ready) begin
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) n_unexpected++;
      else begin
        mon_exp = exp_q.pop_front();
        check("o_reg", o_reg, mon_exp);
`ifdef BS_ZERO_FLAG_EN
        check("o_zero", {31'd0, o_zero}, {31'd0, mon_exp == 32'd0});
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 right after the accept edge
  // with in_valid still high so consecutive calls stream back to back.
  task automatic send(input logic [31:0] d, input logic [5:0] a,
                      input logic [1:0] m, input logic [31:0] e);
    bit ok;
    in_valid  = 1'b1;
    in_reg    = d;
    shift_amt = a;
    in_m      = m;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (ok) begin
      exp_q.push_back(e);
      @(posedge clk); #1;
    end else begin
      check("send_timeout", {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
    end
  endtask

  // Drop valid and scramble the operand lines; in-flight ops must not care.
  task automatic idle();
    in_valid  = 1'b0;
    in_reg    = $urandom;
    shift_amt = 6'($urandom_range(0, 63));
    in_m      = 2'($urandom_range(0, 3));
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    check(tag, exp_q.size(), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int acc;
    int del;
    bit saw_stall;

    rst = 1'b1; in_valid = 1'b0; in_reg = '0; shift_amt = '0; in_m = '0; o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_o_reg", o_reg, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef BS_ZERO_FLAG_EN
    check("rst_o_zero", {31'd0, o_zero}, 32'd0);
`endif

    // T1: latency. Accept cycle is c0; o_valid must be low c1..c4, high c5.
    @(posedge clk); #1;
    send(32'h1234_5678, 6'd4, ROL, 32'h2345_6781);
    idle();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("latency_o_valid", {31'd0, o_valid}, {31'd0, i == 5});
      @(posedge clk); #1;
    end
    drain("t1_drain");

    // T1-T3: mode and amount corners, issued back to back.
    send(32'h8000_0001, 6'd1,  ROR, 32'hC000_0000);
    send(32'h1234_5678, 6'd36, ROR, 32'h8123_4567);
    send(32'hFFFF_FFFF, 6'd32, SLL, 32'h0000_0000);
    send(32'h8000_0000, 6'd31, SRA, 32'hFFFF_FFFF);
    send(32'h8000_0000, 6'd63, SRA, 32'hFFFF_FFFF);
    send(32'h4000_0000, 6'd40, SRA, 32'h0000_0000);
    // zero amount is identity in every mode
    send(32'hA5A5_0F0F, 6'd0,  ROL, 32'hA5A5_0F0F);
    send(32'hA5A5_0F0F, 6'd0,  ROR, 32'hA5A5_0F0F);
    send(32'hA5A5_0F0F, 6'd0,  SLL, 32'hA5A5_0F0F);
    send(32'hA5A5_0F0F, 6'd0,  SRA, 32'hA5A5_0F0F);
    send(32'h0000_0001, 6'd31, SLL, 32'h8000_0000);
    send(32'h7FFF_FFFF, 6'd31, SRA, 32'h0000_0000);
    send(32'h8000_0000, 6'd33, ROL, 32'h0000_0001);
    send(32'hF000_0000, 6'd4,  SRA, 32'hFF00_0000);
    send(32'h0000_00FF, 6'd8,  SLL, 32'h0000_FF00);
    send(32'h0000_0001, 6'd63, ROR, 32'h0000_0002);
    send(32'h0000_0F00, 6'd5,  ROR, 32'h0000_0078);
    idle();
    drain("t3_drain");

    // T4: full-rate stream, consumer always ready.
    out_cyc_q.delete();
    for (int k = 0; k < 20; k++) begin
      in_valid  = 1'b1;
      in_reg    = 32'h1;
      shift_amt = 6'(k);
      in_m      = SLL;
      @(negedge clk);
      check("t4_in_ready", {31'd0, in_ready}, 32'd1);
      if (in_ready) exp_q.push_back(32'h1 << k);
      @(posedge clk); #1;
    end
    idle();
    drain("t4_drain");
    check("t4_count", out_cyc_q.size(), 32'd20);
    if (out_cyc_q.size() > 0)
      check("t4_consecutive", out_cyc_q[$] - out_cyc_q[0], 32'd19);

    // T5: same stream with o_ready low for stream cycles 3..12.
    n = 0; acc = 0; del = 0; saw_stall = 1'b0;
    for (int c = 0; c < 200 && n < 20; c++) begin
      o_ready   = !(c >= 3 && c <= 12);
      in_valid  = 1'b1;
      in_reg    = 32'h1;
      shift_amt = 6'(n);
      in_m      = SLL;
      @(negedge clk);
      check("t5_in_ready", {31'd0, in_ready}, {31'd0, ((acc - del) < 5) || o_ready});
      if (in_ready) begin
        exp_q.push_back(32'h1 << n);
        n++;
        acc++;
      end else saw_stall = 1'b1;
      if (o_valid && o_ready) del++;
      @(posedge clk); #1;
    end
    idle();
    o_ready = 1'b1;
    check("t5_all_sent", n, 32'd20);
    check("t5_stalled", {31'd0, saw_stall}, 32'd1);
    drain("t5_drain");

    // T6: reset with three ops in flight; none of them may appear.
    send(32'h0000_0011, 6'd1, SLL, 32'h0000_0022);
    send(32'h0000_0033, 6'd2, SLL, 32'h0000_00CC);
    send(32'h0000_0055, 6'd3, SLL, 32'h0000_02A8);
    idle();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_o_valid", {31'd0, o_valid}, 32'd0);
    check("t6_o_reg", o_reg, 32'd0);
    check("t6_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef BS_ZERO_FLAG_EN
    check("t6_o_zero", {31'd0, o_zero}, 32'd0);
`endif
    repeat (12) @(posedge clk);
    #1;
    // Fresh op after reset still flows normally.
    send(32'hDEAD_BEEF, 6'd16, ROL, 32'hBEEF_DEAD);
    idle();
    drain("t6_drain");

    check("unexpected_outputs", n_unexpected, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
